// File: rtl/player_cmd_scheduler.sv
// player_cmd_scheduler
//
// Merges Bluetooth command bytes and the four on-board buttons into one
// serialized command stream. The block owns the current track index and
// volume. It issues one-cycle load strobes toward the MP3 decoder and waits
// while the decoder reports busy. Bluetooth-originated commands are answered
// with an ack byte over a valid/ready handshake.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   bt_valid     one-cycle strobe, bt_data holds a received byte
//   bt_data      received command byte
//   btn_prev     debounced button level (rising edge = command)
//   btn_next     debounced button level
//   btn_up       debounced button level
//   btn_down     debounced button level
//   dec_busy     decoder busy, no grant and no WAIT exit while high
//   track        current track index (wraps)
//   volume       current volume, 0..15
//   track_load   one-cycle pulse, track just changed
//   vol_load     one-cycle pulse, volume just changed
//   ack_valid    ack byte available
//   ack_data     ack byte, held while ack_valid is high
//   ack_ready    transmit side accepts the ack
//   ovf          sticky, a Bluetooth byte was dropped
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a pending request; grants it when the decoder is free
// WAIT  | a load was issued; hold at least 2 cycles, then until not busy
// ACK   | presenting the ack byte for a Bluetooth command until accepted

module player_cmd_scheduler #(
    parameter int          TRACKS_LOG2 = 3,
    parameter logic [3:0]  VOL_RESET   = 4'd8,
    parameter logic [7:0]  ERR_CODE    = 8'hEE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bt_valid,
    input  logic [7:0]             bt_data,
    input  logic                   btn_prev,
    input  logic                   btn_next,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   dec_busy,
    output logic [TRACKS_LOG2-1:0] track,
    output logic [3:0]             volume,
    output logic                   track_load,
    output logic                   vol_load,
    output logic                   ack_valid,
    output logic [7:0]             ack_data,
    input  logic                   ack_ready,
    output logic                   ovf
);

    localparam int TW = TRACKS_LOG2;

    localparam logic [7:0] CMD_PREV = 8'h01;
    localparam logic [7:0] CMD_NEXT = 8'h02;
    localparam logic [7:0] CMD_UP   = 8'h03;
    localparam logic [7:0] CMD_DOWN = 8'h04;

    // Loaded at grant; WAIT is left only once this reaches zero, which
    // gives the two-cycle minimum dwell.
    localparam logic [1:0] WAIT_LOAD = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t state, state_nxt;

    logic       slot_valid;
    logic [7:0] slot_data;

    // Button bit order: [0]=prev, [1]=next, [2]=up, [3]=down
    logic [3:0] btn_lvl;
    logic [3:0] btn_q;
    logic [3:0] btn_rise;
    logic [3:0] btn_pend;

    logic       grant;
    logic       sel_bt;
    logic [3:0] sel_btn;
    logic [7:0] sel_cmd;
    logic       grant_bt;
    logic [3:0] grant_btn;

    logic          cmd_ok;
    logic [TW-1:0] trk_nxt;
    logic [3:0]    vol_nxt;
    logic          trk_chg;
    logic          vol_chg;
    logic [7:0]    ack_byte;

    logic       cur_bt;
    logic [1:0] wait_cnt;

    assign btn_lvl = {btn_down, btn_up, btn_next, btn_prev};

    // The edge-detector history follows the levels on every clock, reset
    // included, so a button already held when reset releases is not seen
    // as a new press.
    always_ff @(posedge clk) begin
        btn_q <= btn_lvl;
    end

    assign btn_rise = btn_lvl & ~btn_q;

    // Request selection: Bluetooth slot first, then prev, next, up, down.
    always_comb begin
        sel_bt  = 1'b0;
        sel_btn = 4'b0000;
        sel_cmd = 8'h00;
        if (slot_valid) begin
            sel_bt  = 1'b1;
            sel_cmd = slot_data;
        end else if (btn_pend[0]) begin
            sel_btn = 4'b0001;
            sel_cmd = CMD_PREV;
        end else if (btn_pend[1]) begin
            sel_btn = 4'b0010;
            sel_cmd = CMD_NEXT;
        end else if (btn_pend[2]) begin
            sel_btn = 4'b0100;
            sel_cmd = CMD_UP;
        end else if (btn_pend[3]) begin
            sel_btn = 4'b1000;
            sel_cmd = CMD_DOWN;
        end
    end

    assign grant     = (state == ST_IDLE) && (slot_valid || (|btn_pend)) && !dec_busy;
    assign grant_bt  = grant && sel_bt;
    assign grant_btn = grant ? sel_btn : 4'b0000;

    // Command decode and the resulting track/volume values.
    always_comb begin
        cmd_ok  = 1'b1;
        trk_nxt = track;
        vol_nxt = volume;
        if (sel_cmd == CMD_PREV) begin
            trk_nxt = track - TW'(1);
        end else if (sel_cmd == CMD_NEXT) begin
            trk_nxt = track + TW'(1);
        end else if (sel_cmd == CMD_UP) begin
            if (volume != 4'hF) begin
                vol_nxt = volume + 4'd1;
            end
        end else if (sel_cmd == CMD_DOWN) begin
            if (volume != 4'h0) begin
                vol_nxt = volume - 4'd1;
            end
        end else if (sel_cmd[7:3] == 5'b00010) begin
            trk_nxt = TW'(sel_cmd[2:0]);
        end else begin
            cmd_ok = 1'b0;
        end
    end

    assign trk_chg  = (trk_nxt != track);
    assign vol_chg  = (vol_nxt != volume);
    assign ack_byte = cmd_ok ? sel_cmd : ERR_CODE;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    if (trk_chg || vol_chg) begin
                        state_nxt = ST_WAIT;
                    end else if (sel_bt) begin
                        state_nxt = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if ((wait_cnt == 2'd0) && !dec_busy) begin
                    state_nxt = cur_bt ? ST_ACK : ST_IDLE;
                end
            end
            ST_ACK: begin
                if (ack_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            slot_valid <= 1'b0;
            slot_data  <= 8'h00;
            btn_pend   <= 4'b0000;
            ovf        <= 1'b0;
            track      <= '0;
            volume     <= VOL_RESET;
            track_load <= 1'b0;
            vol_load   <= 1'b0;
            ack_valid  <= 1'b0;
            ack_data   <= 8'h00;
            cur_bt     <= 1'b0;
            wait_cnt   <= 2'd0;
        end else begin
            state      <= state_nxt;
            track_load <= grant && trk_chg;
            vol_load   <= grant && vol_chg;
            ack_valid  <= (state_nxt == ST_ACK);

            if (grant) begin
                track    <= trk_nxt;
                volume   <= vol_nxt;
                cur_bt   <= sel_bt;
                wait_cnt <= WAIT_LOAD;
            end else if ((state == ST_WAIT) && (wait_cnt != 2'd0)) begin
                wait_cnt <= wait_cnt - 2'd1;
            end

            if (grant_bt) begin
                ack_data <= ack_byte;
            end

            // A byte arriving in the cycle the slot is granted is accepted.
            if (bt_valid) begin
                if (!slot_valid || grant_bt) begin
                    slot_valid <= 1'b1;
                    slot_data  <= bt_data;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (grant_bt) begin
                slot_valid <= 1'b0;
            end

            // A fresh edge in the grant cycle of the same button re-arms it.
            btn_pend <= (btn_pend & ~grant_btn) | btn_rise;
        end
    end

endmodule

// File: doc/player_cmd_scheduler.md
# player_cmd_scheduler

Command scheduler between the Bluetooth UART command path and the MP3 decoder control registers. It arbitrates Bluetooth command bytes and on-board pushbuttons (prev/next/vol-up/vol-down) into one serialized command stream. It owns the current track index and volume, and issues one-cycle load strobes to the decoder interface, holding off while the decoder is busy. For Bluetooth-originated commands it returns an acknowledge byte to the UART transmit side over a valid/ready handshake.

## Interface
- TRACKS_LOG2, 3, track index width (8 tracks, wraps)
- VOL_RESET, 8, volume value after reset (4-bit, 0..15)
- ERR_CODE, 8'hEE, ack byte for an unrecognized command

- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- BT_VALID  in  1  one-cycle strobe: BT_DATA holds a received byte
- BT_DATA  in  8  received command byte
- BTN_PREV, BTN_NEXT, BTN_UP, BTN_DOWN  in  1 each  debounced button levels; the block detects rising edges internally
- DEC_BUSY  in  1  decoder busy; no new load is issued while high
- TRACK  out  3  current track index
- VOLUME  out  4  current volume
- TRACK_LOAD  out  1  one-cycle pulse: TRACK has changed
- VOL_LOAD  out  1  one-cycle pulse: VOLUME has changed
- ACK_VALID  out  1  ack byte available
- ACK_DATA  out  8  ack byte, stable while ACK_VALID is high
- ACK_READY  in  1  UART transmit side accepts the ack
- OVF  out  1  sticky: a Bluetooth byte was dropped

## Operation
- Command decode:
  - 0x01 prev: TRACK−1, mod 8
  - 0x02 next: TRACK+1, mod 8
  - 0x03 volume up, saturating at 15
  - 0x04 volume down, saturating at 0
  - 0x10–0x17 direct select: TRACK = data[2:0]
  - Any other byte is invalid.
- Bluetooth pending slot:
  - One entry (byte plus valid bit), set on BT_VALID.
  - If the slot is full and not being freed in the same cycle, the new byte is dropped and OVF is set (cleared only by RST).
  - If the slot is freed in the same cycle as BT_VALID, the new byte is accepted.
- Button pending bits:
  - A rising edge on a button sets its pending bit.
  - Further edges while the bit is set are merged, with no overflow.
- Priority when leaving IDLE: Bluetooth slot, then PREV, NEXT, UP, DOWN. The granted pending entry is cleared in the grant cycle.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if a request is pending and DEC_BUSY=0, grant it and apply the update at this edge:
    - The matching load pulse fires only if the value actually changes.
    - Saturated volume, or a direct select equal to the current TRACK, updates nothing and pulses nothing.
    - Invalid byte: no update.
    - Next state is WAIT if a load fired. Otherwise it is ACK for a Bluetooth-origin request, or stays IDLE for a button.
  - WAIT: stay a minimum of 2 cycles, then exit on the first cycle with DEC_BUSY=0. Next state is ACK for a Bluetooth-origin request, IDLE for a button.
  - ACK:
    - ACK_VALID=1; ACK_DATA = the command byte echoed, or ERR_CODE if invalid.
    - Return to IDLE at the edge where ACK_VALID and ACK_READY are both high.
    - ACK_DATA is held constant until that edge.
- Requests continue to be latched in every state.

## Timing
- Reset values:
  - TRACK=0, VOLUME=VOL_RESET.
  - TRACK_LOAD=0, VOL_LOAD=0, ACK_VALID=0, ACK_DATA=0, OVF=0.
  - FSM in IDLE; all pending entries cleared.
  - Button edge detectors are loaded with the current levels, so a button already held at reset release produces no command.
- All outputs are registered.
- Latency, idle block with DEC_BUSY=0:
  - BT_VALID in cycle t: slot set at the end of t; grant in t+1; TRACK/VOLUME updated and the load pulse high in t+2.
  - A button rising edge observed in cycle t follows the same 2-cycle latency.
- ACK_VALID rises in the cycle after WAIT exits, or in the cycle after grant if no load fired.
- Throughput: at most one command per (grant + WAIT + ACK) sequence; back-to-back grants are at least 1 cycle apart.
- RST asserted mid-sequence: immediately forces the reset values, drops any in-flight ack, and clears OVF.

## Test plan
- Reset, then BT byte 0x02 with DEC_BUSY=0 -> TRACK=1, TRACK_LOAD high for exactly 1 cycle 2 cycles after BT_VALID, then ACK_VALID with ACK_DATA=0x02. Hold ACK_READY=0 for 5 cycles -> ACK_VALID and ACK_DATA stay stable.
- From TRACK=0, BT 0x01 -> TRACK=7. Then 0x15 -> TRACK=5. Then 0x15 again -> no TRACK_LOAD, ack 0x15.
- Send 0x03 eight times from VOLUME=8 -> VOLUME ends at 15 with 7 VOL_LOAD pulses. Then 0x04 from VOLUME=0 -> no pulse, ack 0x04. Send 0x7F -> ack 0xEE, no pulses.
- BT_VALID 0x02 and a BTN_PREV edge in the same cycle -> Bluetooth command served first (TRACK 0→1), then PREV (1→0), and only the BT command is acked.
- Hold DEC_BUSY=1, send 0x02, then 0x01 -> first byte held in the slot, second dropped, OVF=1. Release busy -> exactly one TRACK_LOAD.
- Assert RST while in ACK with VOLUME=12 -> ACK_VALID=0, VOLUME=8, OVF=0 in the same cycle, and nothing is issued after reset release.
